inst_axi_bridge: RTL and testbench
==================================

Name: inst_axi_bridge

Overview:
Read-only bridge directly upstream of the fetch stage. It converts the fetch stage's SRAM-like instruction interface (req / addr_ok / data_ok) into AXI3 AR/R channel transactions toward the memory subsystem. It supports up to MAX_OUTSTANDING in-flight reads and returns data strictly in request order. The fetch stage performs its own cancel/discard bookkeeping, so this bridge returns every accepted request exactly once.

Parameters:
MAX_OUTSTANDING, 4, maximum number of accepted requests whose data_ok has not yet been issued (1..15).
INST_ARID, 4'd0, constant AXI ID driven on arid for all instruction reads.

Ports:
clk  input  1  clock.
reset  input  1  Synchronous, active-high reset.
inst_sram_req  input  1  Fetch request valid.
inst_sram_wr  input  1  Write flag; must be 0. Write requests are never accepted.
inst_sram_size  input  2  log2 of the byte count (2 = 4 bytes).
inst_sram_addr  input  32  Fetch address.
inst_sram_addr_ok  output  1  Request accepted this cycle.
inst_sram_data_ok  output  1  inst_sram_rdata is valid this cycle.
inst_sram_rdata  output  32  Returned instruction word.
arid  output  4  Always INST_ARID.
araddr  output  32  Latched request address.
arlen  output  8  Always 0 (single beat).
arsize  output  3  {1'b0, latched size}.
arburst  output  2  Always 2'b01.
arlock  output  2  Always 0.
arcache  output  4  Always 0.
arprot  output  3  Always 0.
arvalid  output  1  AR valid.
arready  input  1  AR ready.
rid  input  4  Ignored.
rdata  input  32  Read data.
rresp  input  2  Ignored; no bus-error exception is raised.
rlast  input  1  Always 1 for single-beat reads; used to qualify the R handshake.
rvalid  input  1  R valid.
rready  output  1  R ready.

Behaviour:
- Reset values:
  - arvalid=0, araddr=0, arsize=0.
  - inst_sram_data_ok=0, inst_sram_rdata=0.
  - outstanding count=0, AR FSM=AR_IDLE.
  - rready=0 while reset is high.
- AR FSM has two states:
  - AR_IDLE: arvalid=0.
  - AR_BUSY: arvalid=1; araddr and arsize are held stable.
- Request acceptance:
  - inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & (state==AR_IDLE) & (cnt < MAX_OUTSTANDING) & ~reset.
  - addr_ok is combinational, in the same cycle as req.
- On accept:
  - araddr and arsize are latched at the next edge.
  - The FSM moves to AR_BUSY, so arvalid rises 1 cycle after addr_ok.
- AR_BUSY → AR_IDLE on arvalid & arready.
  - No new request is accepted in the cycle of the AR handshake. Acceptance resumes the following cycle.
  - Maximum issue rate is therefore one request every 2 cycles.
- rready = ~reset, always high otherwise. The R handshake is rvalid & rready & rlast.
- R handshake at cycle T:
  - inst_sram_rdata <= rdata.
  - inst_sram_data_ok = 1 at cycle T+1, for exactly one cycle.
  - Otherwise data_ok <= 0.
- Minimum latency: addr_ok at T → arvalid at T+1 → rvalid at T+2 at the earliest → data_ok at T+3.
- Outstanding count (cnt, 4 bits):
  - +1 on addr_ok.
  - −1 on inst_sram_data_ok.
  - Unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
  - Never underflows: an R beat with cnt==0 is a protocol violation, and the bench checks it by assertion.
- inst_sram_rdata holds its last value while data_ok=0.
- Requests with wr=1 are never accepted. The bridge does not stall or error on them.
- Ordering: a single ARID and an in-order slave are required. Data is returned in acceptance order.
- Reset asserted mid-transaction:
  - All state returns to reset values on the next edge.
  - Pending AR is abandoned.
  - In-flight R beats that arrive after reset deasserts are a system-level violation. The whole SoC resets together.

Test Plan:
- Single fetch: req addr=0x1c000000 size=2, arready tied 1, rvalid 2 cycles after AR with rdata=0x02800c0c → addr_ok at cycle 0, arvalid=1 with araddr=0x1c000000 and arsize=3'b010 at cycle 1, data_ok=1 with rdata=0x02800c0c one cycle after the R beat, cnt returns to 0.
- AR backpressure: arready=0 for 5 cycles while req is held high → addr_ok only at cycle 0, arvalid and araddr stable for all 5 cycles, no second addr_ok until the cycle after the arready handshake.
- Outstanding limit: MAX_OUTSTANDING=4, slave withholds R, req held high with incrementing addresses → exactly 4 addr_ok; the 5th is withheld until the first data_ok; data returns in address order.
- Simultaneous inc/dec: an addr_ok in the same cycle as data_ok with cnt=2 → cnt stays 2.
- Write rejection: req=1, wr=1 for 10 cycles → addr_ok=0 and arvalid=0 throughout.
- Reset mid-flight: reset while arvalid=1 and cnt=1 → next cycle arvalid=0, cnt=0, data_ok=0; a fresh request is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/inst_axi_bridge_if.sv
// Fetch-side SRAM-like request/response signals and the AXI3 AR/R channels.
// The bridge uses the master modport; the fetch stage / memory environment uses slave.
interface inst_axi_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like interface to AXI3 AR/R,
// with up to MAX_OUTSTANDING in-order reads in flight.
module inst_axi_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [3:0]  INST_ARID       = 4'd0
) (
  input logic               clk,
  input logic               reset,
  inst_axi_bridge_if.master bus
);

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_t;

  ar_state_t   state;
  ar_state_t   state_next;
  logic        arvalid_c;
  logic        addr_ok;
  logic        r_hs;
  logic [3:0]  cnt;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        unused_ok;

  // One AR in flight at a time; no accept during the AR handshake cycle.
  assign addr_ok = bus.inst_sram_req & ~bus.inst_sram_wr & (state == AR_IDLE)
                 & (cnt < 4'(MAX_OUTSTANDING)) & ~reset;
  assign r_hs    = bus.rvalid & bus.rready & bus.rlast;

  always_comb begin
    state_next = state;
    arvalid_c  = 1'b0;
    case (state)
      AR_IDLE: if (addr_ok) state_next = AR_BUSY;
      AR_BUSY: begin
        arvalid_c = 1'b1;
        if (bus.arready) state_next = AR_IDLE;
      end
      default: state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= AR_IDLE;
      araddr_q  <= '0;
      arsize_q  <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      data_ok_q <= r_hs;
      if (addr_ok) begin
        araddr_q <= bus.inst_sram_addr;
        arsize_q <= {1'b0, bus.inst_sram_size};
      end
      if (r_hs) rdata_q <= bus.rdata;
      case ({addr_ok, data_ok_q})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;

  assign bus.arid    = INST_ARID;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = '0;
  assign bus.arsize  = arsize_q;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = '0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign bus.arvalid = arvalid_c;
  assign bus.rready  = ~reset;

  assign unused_ok = ^{bus.rid, bus.rresp};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Randomized bench for inst_axi_bridge with a request-order reference model and a
// behavioural AXI read slave.
module tb_inst_axi_bridge;
  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_axi_bridge_if bus ();

  inst_axi_bridge #(.MAX_OUTSTANDING(MAXO), .INST_ARID(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0c0c;
    return {a[15:0], a[31:16]} ^ 32'h5a5a_3c3c ^ (a * 32'd2654435761);
  endfunction

  // stimulus knobs
  logic        d_reset, d_req, d_wr, d_arready;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic        k_withhold;
  int          k_dmin, k_dmax;

  // reference model: accepted-address order, AR slot, count, pending data_ok
  logic [31:0] q_order[$];
  logic [31:0] s_addr[$];
  int          s_ready[$];
  logic        m_pend, m_dok;
  logic [31:0] m_araddr, m_last;
  logic [2:0]  m_arsize;
  int          m_cnt;

  logic        o_addr_ok, o_arvalid, o_data_ok, o_rready;
  logic [31:0] o_araddr, o_rdata;
  logic [2:0]  o_arsize;

  task automatic run_cycle();
    logic exp_acc;
    logic dok_now;
    @(posedge clk);
    #1;
    reset              = d_reset;
    bus.inst_sram_req  = d_req;
    bus.inst_sram_wr   = d_wr;
    bus.inst_sram_size = d_size;
    bus.inst_sram_addr = d_addr;
    bus.arready        = d_arready;
    bus.rlast          = 1'b1;
    bus.rid            = 4'($urandom);
    bus.rresp          = 2'($urandom);
    if (!d_reset && !k_withhold && s_addr.size() > 0 && s_ready[0] <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = mem_word(s_addr[0]);
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
    end
    @(negedge clk);
    o_addr_ok = bus.inst_sram_addr_ok;
    o_arvalid = bus.arvalid;
    o_araddr  = bus.araddr;
    o_arsize  = bus.arsize;
    o_data_ok = bus.inst_sram_data_ok;
    o_rdata   = bus.inst_sram_rdata;
    o_rready  = bus.rready;

    exp_acc = d_req && !d_wr && !m_pend && (m_cnt < int'(MAXO)) && !d_reset;
    check("addr_ok", o_addr_ok, exp_acc);
    check("arvalid", o_arvalid, m_pend);
    if (m_pend) begin
      check("araddr", o_araddr, m_araddr);
      check("arsize", o_arsize, m_arsize);
      check("ar_const", {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
            {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    end
    check("rready", o_rready, !d_reset);
    check("data_ok", o_data_ok, m_dok);
    check("rdata_hold", o_rdata, m_last);
    if (m_dok) begin
      if (q_order.size() == 0) check("order_nonempty", 0, 1);
      else check("rdata_order", o_rdata, mem_word(q_order.pop_front()));
    end
    if (bus.rvalid && !d_reset)
      assert (m_cnt > 0) else $error("R beat with no request outstanding");

    dok_now = m_dok;
    if (d_reset) begin
      m_pend = 1'b0; m_dok = 1'b0; m_last = '0; m_cnt = 0;
      q_order.delete(); s_addr.delete(); s_ready.delete();
    end else begin
      if (m_pend && d_arready) begin
        m_pend = 1'b0;
        s_addr.push_back(m_araddr);
        s_ready.push_back(cyc + 1 + $urandom_range(k_dmax, k_dmin));
      end
      if (exp_acc) begin
        m_pend   = 1'b1;
        m_araddr = d_addr;
        m_arsize = {1'b0, d_size};
        q_order.push_back(d_addr);
      end
      m_dok = bus.rvalid;
      if (bus.rvalid) begin
        m_last = bus.rdata;
        void'(s_addr.pop_front());
        void'(s_ready.pop_front());
      end
      m_cnt = m_cnt + int'(exp_acc) - int'(dok_now);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    d_req = 1'b0; d_wr = 1'b0; d_arready = 1'b1; k_withhold = 1'b0;
    repeat (n) run_cycle();
  endtask

  initial begin
    int acc, arv;
    logic [31:0] tmp, next_addr;
    reset = 1'b1;
    bus.inst_sram_req = 1'b0; bus.inst_sram_wr = 1'b0; bus.inst_sram_size = 2'd2;
    bus.inst_sram_addr = '0; bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rid = '0; bus.rresp = '0; bus.rlast = 1'b1;
    d_reset = 1'b1; d_req = 1'b0; d_wr = 1'b0; d_size = 2'd2; d_addr = '0; d_arready = 1'b1;
    k_withhold = 1'b0; k_dmin = 0; k_dmax = 3;
    m_pend = 1'b0; m_dok = 1'b0; m_last = '0; m_araddr = '0; m_arsize = '0; m_cnt = 0;

    repeat (3) run_cycle();
    check("rst_arvalid", o_arvalid, 0);
    check("rst_araddr", o_araddr, 0);
    check("rst_arsize", o_arsize, 0);
    check("rst_data_ok", o_data_ok, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_rready", o_rready, 0);
    d_reset = 1'b0;

    // single fetch, R beat two cycles after the AR handshake
    k_dmin = 1; k_dmax = 1;
    d_req = 1'b1; d_addr = 32'h1c00_0000; d_size = 2'd2;
    run_cycle();
    check("sf_addr_ok", o_addr_ok, 1);
    d_req = 1'b0;
    run_cycle();
    check("sf_arvalid", o_arvalid, 1);
    check("sf_araddr", o_araddr, 32'h1c00_0000);
    check("sf_arsize", o_arsize, 3'b010);
    run_cycle();
    run_cycle();
    run_cycle();
    check("sf_data_ok", o_data_ok, 1);
    check("sf_rdata", o_rdata, 32'h0280_0c0c);
    run_cycle();
    check("sf_data_ok_pulse", o_data_ok, 0);

    // AR backpressure
    k_dmin = 0; k_dmax = 3;
    d_arready = 1'b0; d_req = 1'b1; d_addr = 32'h1c00_0100;
    run_cycle();
    check("bp_first_acc", o_addr_ok, 1);
    acc = 0; arv = 0;
    repeat (5) begin
      run_cycle();
      acc += int'(o_addr_ok);
      arv += int'(o_arvalid && o_araddr == 32'h1c00_0100);
    end
    check("bp_extra_acc", acc, 0);
    check("bp_ar_stable", arv, 5);
    d_arready = 1'b1;
    run_cycle();
    check("bp_no_acc_at_hs", o_addr_ok, 0);
    run_cycle();
    check("bp_resume", o_addr_ok, 1);
    idle(20);

    // outstanding limit with R withheld
    k_withhold = 1'b1; d_req = 1'b1; next_addr = 32'h2000_0000; acc = 0;
    repeat (16) begin
      d_addr = next_addr;
      run_cycle();
      if (o_addr_ok) begin
        acc++;
        next_addr += 32'd4;
      end
    end
    check("lim_accepts", acc, MAXO);
    k_withhold = 1'b0; k_dmin = 0; k_dmax = 2;
    repeat (30) begin
      d_addr = next_addr;
      run_cycle();
      if (o_addr_ok) next_addr += 32'd4;
    end
    idle(30);

    // write requests are never accepted
    d_req = 1'b1; d_wr = 1'b1; acc = 0; arv = 0;
    repeat (10) begin
      d_addr = next_addr;
      run_cycle();
      acc += int'(o_addr_ok);
      arv += int'(o_arvalid);
    end
    check("wr_acc", acc, 0);
    check("wr_arvalid", arv, 0);
    d_wr = 1'b0;

    // random traffic
    k_dmin = 0; k_dmax = 4;
    repeat (3000) begin
      tmp        = $urandom;
      d_addr     = {tmp[31:2], 2'b00};
      d_req      = ($urandom_range(3, 0) != 0);
      d_wr       = ($urandom_range(15, 0) == 0);
      d_size     = 2'($urandom_range(2, 0));
      d_arready  = ($urandom_range(2, 0) != 0);
      k_withhold = ($urandom_range(3, 0) == 0);
      run_cycle();
    end
    d_size = 2'd2;
    idle(40);

    // reset while an AR is pending
    d_arready = 1'b0; d_req = 1'b1; d_addr = 32'h3000_0000;
    run_cycle();
    check("rm_acc", o_addr_ok, 1);
    d_req = 1'b0;
    run_cycle();
    check("rm_arvalid_pend", o_arvalid, 1);
    d_reset = 1'b1;
    run_cycle();
    d_reset = 1'b0; d_req = 1'b1; d_addr = 32'h3000_0040; d_arready = 1'b1;
    run_cycle();
    check("rm_arvalid_cleared", o_arvalid, 0);
    check("rm_data_ok", o_data_ok, 0);
    check("rm_fresh_acc", o_addr_ok, 1);
    idle(20);
    check("end_order_drained", q_order.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
